// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative radix-2 multiply/divide engine for the EX stage.
// MSB-first shift-add multiply and restoring divide, with sign fix-up in a final cycle.
module ex_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] hilo,
  output logic               div0
);

  localparam logic [2:0] OpMult = 3'd1;
  localparam logic [2:0] OpDiv  = 3'd3;
  localparam logic [2:0] OpDivu = 3'd4;

  typedef enum logic [1:0] {Idle, Run, Fix} state_t;

  state_t state, stateNxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem, q, m, rawA;
  logic [WIDTH-1:0]   aAbs, bAbs, qFix, rFix;
  logic [WIDTH:0]     shifted, trial;
  logic               isDiv, sgnRes, sgnDvd, bZero;
  logic               opValid, opSigned, opDiv, accept;

  assign opValid  = (op >= OpMult) && (op <= OpDivu);
  assign opSigned = (op == OpMult) || (op == OpDiv);
  assign opDiv    = (op == OpDiv) || (op == OpDivu);
  assign accept   = (state == Idle) && start && opValid && !flush;
  assign stall    = !rst && !flush && (accept || state != Idle);

  assign aAbs = (opSigned && a[WIDTH-1]) ? -a : a;
  assign bAbs = (opSigned && b[WIDTH-1]) ? -b : b;

  // q holds the multiplier while multiplying, dividend/quotient while dividing
  assign shifted = {rem, q[WIDTH-1]};
  assign trial   = shifted - {1'b0, m};

  assign qFix = sgnRes ? -q : q;
  assign rFix = sgnDvd ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= Idle;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      Idle:    if (accept) stateNxt = Run;
      Run:     if (cnt == CNT_W'(1)) stateNxt = Fix;
      Fix:     stateNxt = Idle;
      default: stateNxt = Idle;
    endcase
    if (flush) stateNxt = Idle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      q      <= '0;
      m      <= '0;
      rawA   <= '0;
      isDiv  <= 1'b0;
      sgnRes <= 1'b0;
      sgnDvd <= 1'b0;
      bZero  <= 1'b0;
      hilo   <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      unique case (state)
        Idle: if (accept) begin
          m      <= opDiv ? bAbs : aAbs;
          q      <= opDiv ? aAbs : bAbs;
          acc    <= '0;
          rem    <= '0;
          rawA   <= a;
          bZero  <= (b == '0);
          isDiv  <= opDiv;
          sgnRes <= opSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
          sgnDvd <= opSigned && a[WIDTH-1];
          cnt    <= CNT_W'(WIDTH);
        end
        Run: begin
          cnt <= cnt - CNT_W'(1);
          if (isDiv) begin
            if (trial[WIDTH]) begin
              rem <= shifted[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end else begin
              rem <= trial[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b1};
            end
          end else begin
            acc <= {acc[2*WIDTH-2:0], 1'b0}
                 + (q[WIDTH-1] ? {{WIDTH{1'b0}}, m} : '0);
            q   <= {q[WIDTH-2:0], 1'b0};
          end
        end
        Fix: if (!flush) begin
          done <= 1'b1;
          div0 <= isDiv && bZero;
          if (isDiv)
            hilo <= bZero ? {rawA, {WIDTH{1'b1}}} : {rFix, qFix};
          else
            hilo <= sgnRes ? -acc : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// tb_ex_muldiv_iter: random + directed bench for ex_muldiv_iter.
// A cycle-level expectation queue drives one per-cycle compare process.
module tb_ex_muldiv_iter;
  localparam int W  = 32;
  localparam int W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, flush, stall, done, div0;
  logic [2:0]     op;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] hilo;

  logic        rst8, start8, flush8, stall8, done8, div08;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] hilo8;

  ex_muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .hilo(hilo), .div0(div0)
  );

  ex_muldiv_iter #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .stall(stall8), .done(done8), .hilo(hilo8),
    .div0(div08)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit checking = 1'b0;

  typedef struct {
    int          at;
    logic [63:0] hl;
    logic        d0;
  } exp_t;

  exp_t        expQ[$];
  int          busyFrom = 0;
  int          busyTo = -1;
  logic [63:0] expHilo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [64:0] act, logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands; returns {div0, hilo}.
  function automatic logic [64:0] model(logic [2:0] o, logic [31:0] x,
                                        logic [31:0] y, int w);
    logic [63:0] wm, hm, ux, uy, r;
    longint      sx, sy, t;
    logic        d0;
    wm = (64'h1 << w) - 64'h1;
    hm = (w == 32) ? '1 : ((64'h1 << (2 * w)) - 64'h1);
    ux = {32'b0, x} & wm;
    uy = {32'b0, y} & wm;
    t  = longint'(ux << (64 - w));
    sx = t >>> (64 - w);
    t  = longint'(uy << (64 - w));
    sy = t >>> (64 - w);
    d0 = 1'b0;
    if (o == 3'd1) r = 64'(sx * sy);
    else if (o == 3'd2) r = ux * uy;
    else if (uy == 0) begin
      r  = (ux << w) | wm;
      d0 = 1'b1;
    end else if (o == 3'd3)
      r = ((64'(sx % sy) & wm) << w) | (64'(sx / sy) & wm);
    else r = ((ux % uy) << w) | (ux / uy);
    return {d0, r & hm};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  // One cycle of 32-bit stimulus; updates the expectation model.
  task automatic drive(bit s, logic [2:0] o, logic [31:0] x,
                       logic [31:0] y, bit f);
    exp_t        e;
    logic [64:0] mr;
    @(posedge clk);
    #1;
    start = s; op = o; a = x; b = y; flush = f;
    if (f) begin
      if (busyTo >= cyc) busyTo = cyc - 1;
      while (expQ.size() > 0 && expQ[$].at > cyc) void'(expQ.pop_back());
    end else if (s && o >= 3'd1 && o <= 3'd4 && cyc > busyTo) begin
      mr = model(o, x, y, W);
      e.at = cyc + W + 2;
      e.hl = mr[63:0];
      e.d0 = mr[64];
      expQ.push_back(e);
      busyFrom = cyc;
      busyTo = cyc + W + 1;
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("stall", 65'(stall), 65'(cyc >= busyFrom && cyc <= busyTo));
      if (expQ.size() > 0 && expQ[0].at == cyc) begin
        chk("done", 65'(done), 65'(1));
        chk("hilo", 65'(hilo), 65'(expQ[0].hl));
        chk("div0", 65'(div0), 65'(expQ[0].d0));
        expHilo = expQ[0].hl;
        void'(expQ.pop_front());
      end else begin
        chk("no_done", 65'(done), 65'(0));
        chk("hilo_hold", 65'(hilo), 65'(expHilo));
      end
    end
  end

  task automatic dirOp(bit pre, logic [2:0] o, logic [31:0] x,
                       logic [31:0] y, logic [63:0] eh, bit ed0, bit nxt,
                       logic [2:0] no, logic [31:0] nx, logic [31:0] ny);
    if (!pre) drive(1'b1, o, x, y, 1'b0);
    repeat (W + 1)
      drive(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, 1'b0);
    drive(nxt, no, nx, ny, 1'b0);
    @(negedge clk);
    chk("dir_done", 65'(done), 65'(1));
    chk("dir_hilo", 65'(hilo), 65'(eh));
    chk("dir_div0", 65'(div0), 65'(ed0));
  endtask

  task automatic run8(logic [2:0] o, logic [7:0] x, logic [7:0] y,
                      logic [15:0] eh, bit useLit);
    logic [64:0] mr;
    mr = model(o, {24'b0, x}, {24'b0, y}, W8);
    @(posedge clk);
    #1;
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    repeat (W8 + 2) begin
      @(posedge clk);
      #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    end
    @(negedge clk);
    chk("w8_done", 65'(done8), 65'(1));
    chk("w8_hilo", 65'(hilo8), useLit ? 65'(eh) : 65'(mr[15:0]));
    chk("w8_div0", 65'(div08), 65'(mr[64]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5; flush = 1'b0;
    rst8 = 1'b1; start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0; flush8 = 1'b0;

    chk("model_mult", model(3'd1, 32'hFFFF_FFFD, 32'd7, 32),
        {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
    chk("model_div", model(3'd3, 32'hFFFF_FFF9, 32'd2, 32),
        {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
    chk("model_divu", model(3'd4, 32'd100, 32'd7, 32),
        {1'b0, 64'h0000_0002_0000_000E});
    chk("model_div0", model(3'd4, 32'd100, 32'd0, 32),
        {1'b1, 64'h0000_0064_FFFF_FFFF});

    repeat (2) begin
      @(negedge clk);
      chk("rst_stall", 65'(stall), 65'(0));
      chk("rst_done", 65'(done), 65'(0));
      chk("rst_hilo", 65'(hilo), 65'(0));
      chk("rst_div0", 65'(div0), 65'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0; rst8 = 1'b0; start = 1'b0; op = 3'd0;
    checking = 1'b1;

    dirOp(1'b0, 3'd1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0,
          1'b0, 3'd0, 32'd0, 32'd0);
    dirOp(1'b0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
          1'b0, 1'b1, 3'd4, 32'd100, 32'd7);
    dirOp(1'b1, 3'd4, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0,
          1'b0, 3'd0, 32'd0, 32'd0);
    dirOp(1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0,
          1'b0, 3'd0, 32'd0, 32'd0);
    dirOp(1'b0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000,
          1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    dirOp(1'b0, 3'd4, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1'b1,
          1'b0, 3'd0, 32'd0, 32'd0);
    dirOp(1'b0, 3'd3, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b1,
          1'b0, 3'd0, 32'd0, 32'd0);

    for (int k = 0; k < 8; k++) begin
      if (k == 0 || k > 4) drive(1'b1, 3'(k), $urandom, $urandom, 1'b0);
    end
    drive(1'b1, 3'd1, 32'd5, 32'd6, 1'b0);
    repeat (9) drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    repeat (40) drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 3'd2, 32'd9, 32'd9, 1'b1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    dirOp(1'b0, 3'd1, 32'd5, 32'd6, 64'h0000_0000_0000_001E, 1'b0,
          1'b0, 3'd0, 32'd0, 32'd0);

    repeat (1500) begin
      drive(($urandom % 3) == 0,
            ($urandom % 5 == 0) ? 3'($urandom % 8) : 3'(1 + $urandom % 4),
            rnd32(), rnd32(), ($urandom % 50) == 0);
    end
    repeat (W + 4) drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("drained", 65'(expQ.size()), 65'(0));

    run8(3'd1, 8'h80, 8'h80, 16'h4000, 1'b1);
    run8(3'd3, 8'h80, 8'hFF, 16'h0080, 1'b1);
    for (int k = 0; k < 30; k++) begin
      run8(3'(1 + $urandom % 4), 8'(rnd32()), 8'(rnd32()), 16'h0, 1'b0);
    end

    @(posedge clk);
    #1;
    start8 = 1'b1; op8 = 3'd1; a8 = 8'h12; b8 = 8'h34;
    repeat (4) begin
      @(posedge clk);
      #1;
      start8 = 1'b0;
    end
    chk("w8_busy", 65'(stall8), 65'(1));
    #3;
    rst8 = 1'b1;
    #1;
    chk("w8_rst_stall", 65'(stall8), 65'(0));
    chk("w8_rst_done", 65'(done8), 65'(0));
    chk("w8_rst_hilo", 65'(hilo8), 65'(0));
    chk("w8_rst_div0", 65'(div08), 65'(0));
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("w8_rst_nodone", 65'(done8), 65'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
